qsort_batch_sched: RTL and testbench

Job-level scheduler for the 10-element sorting engine in the user project. Takes an arbitrary-length job of N 32-bit words on AXI-Stream and cuts it into 10-word batches. Pads a short final batch, sequences each batch through the engine and forwards only the real sorted words downstream. Software controls it through a small register port that carries length, start, done, idle and error.

---
 rtl/qsort_batch_sched_if.sv | 52 +++++
 rtl/qsort_batch_sched.sv | 211 +++++++++++++++++++++
 tb/tb_qsort_batch_sched.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qsort_batch_sched_if.sv
// Stream bundle between qsort_batch_sched and its neighbours: the upstream
// job source (ss_*), the 10-element sort engine (e_in_* / e_out_*) and the
// downstream sink (sm_*).
//
// Handshake rule for every channel in this bundle: a word transfers on a
// rising axis_clk edge where valid and ready are both 1. The producer keeps
// data/last stable while valid is high and not yet accepted. The consumer
// may raise or drop ready freely.
//
// Modports:
//   master - the scheduler side (drives ss_tready, e_in_*, e_out_ready, sm_*)
//   slave  - the environment side (source, engine and sink)
interface qsort_batch_sched_if #(
  parameter int DW = 32
);
  logic          ss_tvalid;
  logic          ss_tlast;
  logic [DW-1:0] ss_tdata;
  logic          ss_tready;
  logic          e_in_valid;
  logic [DW-1:0] e_in_data;
  logic          e_in_ready;
  logic          e_out_valid;
  logic [DW-1:0] e_out_data;
  logic          e_out_ready;
  logic          sm_tvalid;
  logic          sm_tlast;
  logic [DW-1:0] sm_tdata;
  logic          sm_tready;

  modport master (
    input  ss_tvalid, ss_tlast, ss_tdata,
    output ss_tready,
    output e_in_valid, e_in_data,
    input  e_in_ready,
    input  e_out_valid, e_out_data,
    output e_out_ready,
    output sm_tvalid, sm_tlast, sm_tdata,
    input  sm_tready
  );

  modport slave (
    output ss_tvalid, ss_tlast, ss_tdata,
    input  ss_tready,
    input  e_in_valid, e_in_data,
    output e_in_ready,
    output e_out_valid, e_out_data,
    input  e_out_ready,
    input  sm_tvalid, sm_tlast, sm_tdata,
    output sm_tready
  );
endinterface

// File: rtl/qsort_batch_sched.sv
// qsort_batch_sched: cuts an AXI-Stream job of LEN words into pBATCH-word
// batches for the sort engine, pads a short final batch with pPAD, and
// forwards only the real sorted words downstream.
//
// Ports:
//   axis_clk, rst_n        clock, synchronous active-low reset
//   cfg_we/cfg_re          register write / read strobes
//   cfg_addr, cfg_wdata    register address / write data
//   cfg_rdata              registered read data (valid the cycle after cfg_re)
//   bus (master modport)   ss_* upstream, e_in_*/e_out_* engine, sm_* downstream
//   dbg_state              current FSM state (IDLE=0 FEED=1 PAD=2 DRAIN=3 FIN=4)
//
// Registers: 0x00 CTRL {err_short, ap_idle, ap_done, ap_start},
//            0x10 LEN, 0x14 PERF (cycle count of the last job).
// Optional feature: define QSORT_SCHED_PERF_EN to build the PERF counter;
// without it 0x14 reads 0.
module qsort_batch_sched #(
  parameter int                     pDATA_WIDTH = 32,
  parameter int                     pLEN_WIDTH  = 16,
  parameter int                     pBATCH      = 10,
  parameter logic [pDATA_WIDTH-1:0] pPAD        = pDATA_WIDTH'(32'hFFFF_FFFF)
) (
  input  logic                   axis_clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic                   cfg_re,
  input  logic [7:0]             cfg_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_wdata,
  output logic [pDATA_WIDTH-1:0] cfg_rdata,
  qsort_batch_sched_if.master    bus,
  output logic [2:0]             dbg_state
);
  localparam int KW = $clog2(pBATCH + 1);
  localparam logic [KW-1:0] BATCH_K  = KW'(pBATCH);
  localparam logic [KW-1:0] LAST_IDX = KW'(pBATCH - 1);
  localparam logic [7:0] ADDR_CTRL = 8'h00;
  localparam logic [7:0] ADDR_LEN  = 8'h10;
  localparam logic [7:0] ADDR_PERF = 8'h14;

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_PAD, S_DRAIN, S_FIN} state_t;

  state_t                  state;
  logic [pLEN_WIDTH-1:0]   len_r;
  logic [pLEN_WIDTH-1:0]   rem;      // real words still owed for this job
  logic [KW-1:0]           k;        // real words in the current batch
  logic [KW-1:0]           idx;      // engine slot pushed (FEED/PAD) or popped (DRAIN)
  logic                    ap_start_r;
  logic                    ap_done_r;
  logic                    err_short_r;
  logic                    ap_idle;
  logic                    in_fire;
  logic                    out_fire;
  logic [KW-1:0]           k_nxt;
  logic [pDATA_WIDTH-1:0]  ctrl_word;
  logic [pDATA_WIDTH-1:0]  rd_mux;
  logic [31:0]             perf_rd;
  logic                    unused_wdata;

  assign ap_idle   = (state == S_IDLE);
  assign in_fire   = bus.e_in_valid && bus.e_in_ready;
  assign out_fire  = bus.e_out_valid && bus.e_out_ready;
  assign k_nxt     = k + KW'(1);
  assign dbg_state = state;
  assign ctrl_word = {{(pDATA_WIDTH-4){1'b0}}, err_short_r, ap_idle, ap_done_r, ap_start_r};
  assign unused_wdata = ^cfg_wdata[pDATA_WIDTH-1:pLEN_WIDTH];

  // Stream steering. FEED is a zero-latency pass-through; in DRAIN the
  // engine slots at or beyond k hold pad words and are popped silently.
  always_comb begin
    bus.ss_tready   = 1'b0;
    bus.e_in_valid  = 1'b0;
    bus.e_in_data   = '0;
    bus.e_out_ready = 1'b0;
    bus.sm_tvalid   = 1'b0;
    bus.sm_tlast    = 1'b0;
    bus.sm_tdata    = '0;
    case (state)
      S_FEED: begin
        bus.ss_tready  = bus.e_in_ready;
        bus.e_in_valid = bus.ss_tvalid;
        bus.e_in_data  = bus.ss_tdata;
      end
      S_PAD: begin
        bus.e_in_valid = 1'b1;
        bus.e_in_data  = pPAD;
      end
      S_DRAIN: begin
        if (idx < k) begin
          bus.sm_tvalid   = bus.e_out_valid;
          bus.e_out_ready = bus.sm_tready;
          bus.sm_tdata    = bus.e_out_data;
          bus.sm_tlast    = bus.e_out_valid && (rem == pLEN_WIDTH'(k)) && (idx == k - KW'(1));
        end else begin
          bus.e_out_ready = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (cfg_addr)
      ADDR_CTRL: rd_mux = ctrl_word;
      ADDR_LEN:  rd_mux = pDATA_WIDTH'(len_r);
      ADDR_PERF: rd_mux = pDATA_WIDTH'(perf_rd);
      default:   rd_mux = '0;
    endcase
  end

  // The FSM case sits after the clear-on-read logic so that a flag set in
  // the same cycle as a CTRL read survives (the read still returns the old value).
  always_ff @(posedge axis_clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len_r       <= '0;
      rem         <= '0;
      k           <= '0;
      idx         <= '0;
      ap_start_r  <= 1'b0;
      ap_done_r   <= 1'b0;
      err_short_r <= 1'b0;
      cfg_rdata   <= '0;
    end else begin
      if (cfg_we && (state == S_IDLE)) begin
        if ((cfg_addr == ADDR_CTRL) && cfg_wdata[0]) ap_start_r <= 1'b1;
        if (cfg_addr == ADDR_LEN) len_r <= cfg_wdata[pLEN_WIDTH-1:0];
      end
      if (cfg_re) begin
        cfg_rdata <= rd_mux;
        if (cfg_addr == ADDR_CTRL) begin
          ap_done_r   <= 1'b0;
          err_short_r <= 1'b0;
        end
      end
      case (state)
        S_IDLE: begin
          if (ap_start_r) begin
            ap_start_r <= 1'b0;
            k          <= '0;
            idx        <= '0;
            rem        <= len_r;
            state      <= (len_r == '0) ? S_FIN : S_FEED;
          end
        end
        S_FEED: begin
          if (in_fire) begin
            k   <= k_nxt;
            idx <= k_nxt;
            // Early tlast truncates the job to the words actually received.
            if (bus.ss_tlast && (pLEN_WIDTH'(k_nxt) < rem)) begin
              err_short_r <= 1'b1;
              rem         <= pLEN_WIDTH'(k_nxt);
            end
            if (k_nxt == BATCH_K) begin
              idx   <= '0;
              state <= S_DRAIN;
            end else if ((pLEN_WIDTH'(k_nxt) == rem) || bus.ss_tlast) begin
              state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          if (in_fire) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= S_DRAIN;
            end else begin
              idx <= idx + KW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (out_fire) begin
            if (idx == LAST_IDX) begin
              rem   <= rem - pLEN_WIDTH'(k);
              k     <= '0;
              idx   <= '0;
              state <= (rem == pLEN_WIDTH'(k)) ? S_FIN : S_FEED;
            end else begin
              idx <= idx + KW'(1);
            end
          end
        end
        S_FIN: begin
          ap_done_r <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef QSORT_SCHED_PERF_EN
  // Job cycle counter: zeroed when a job starts, counts while busy,
  // saturates, and holds its value once back in IDLE.
  logic [31:0] perf_cnt;
  always_ff @(posedge axis_clk) begin
    if (!rst_n) begin
      perf_cnt <= '0;
    end else if ((state == S_IDLE) && ap_start_r) begin
      perf_cnt <= '0;
    end else if ((state != S_IDLE) && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end
  assign perf_rd = perf_cnt;
`else
  assign perf_rd = '0;
`endif
endmodule

// File: tb/tb_qsort_batch_sched.sv
module tb_qsort_batch_sched;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic          axis_clk = 1'b0;
  logic          rst_n    = 1'b0;
  logic          cfg_we   = 1'b0;
  logic          cfg_re   = 1'b0;
  logic [7:0]    cfg_addr = 8'h00;
  logic [DW-1:0] cfg_wdata = '0;
  logic [DW-1:0] cfg_rdata;
  logic [2:0]    dbg_state;

  always #5 axis_clk = ~axis_clk;

  qsort_batch_sched_if #(.DW(DW)) bus ();

  qsort_batch_sched dut (
    .axis_clk  (axis_clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_re    (cfg_re),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- environment models ----------------
  logic [32:0] src_q[$];   // {last, data}
  logic [32:0] rx_q[$];    // {last, data} seen downstream
  logic [32:0] exp_q[$];   // scoreboard expectations
  logic [32:0] src_ent;
  bit          eng_stall = 1'b0;
  bit          sink_rand = 1'b0;
  int          ss_fires = 0, ein_fires = 0, pad_fires = 0, eout_fires = 0, sm_fires = 0, tl_cnt = 0;

  // Upstream source: presents queued words in order.
  always @(posedge axis_clk) begin
    if (!rst_n) begin
      src_q.delete();
      bus.ss_tvalid <= 1'b0;
      bus.ss_tdata  <= '0;
      bus.ss_tlast  <= 1'b0;
    end else if (!bus.ss_tvalid || bus.ss_tready) begin
      if (src_q.size() != 0) begin
        src_ent = src_q.pop_front();
        bus.ss_tvalid <= 1'b1;
        bus.ss_tdata  <= src_ent[31:0];
        bus.ss_tlast  <= src_ent[32];
      end else begin
        bus.ss_tvalid <= 1'b0;
        bus.ss_tdata  <= '0;
        bus.ss_tlast  <= 1'b0;
      end
    end
  end

  // Downstream sink ready pattern.
  always @(posedge axis_clk) begin
    if (!rst_n) bus.sm_tready <= 1'b0;
    else        bus.sm_tready <= sink_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Sort-engine model: collect 10 words, sort ascending, emit 10 words.
  logic [31:0] ebuf [10];
  logic [31:0] etmp;
  int          ecnt = 0, ocnt = 0;
  bit          eout = 1'b0;
  always @(posedge axis_clk) begin
    if (!rst_n) begin
      ecnt = 0; ocnt = 0; eout = 1'b0;
    end else if (!eout) begin
      if (bus.e_in_valid && bus.e_in_ready) begin
        ebuf[ecnt] = bus.e_in_data;
        ecnt++;
        if (ecnt == 10) begin
          for (int a = 0; a < 9; a++)
            for (int b = 0; b < 9 - a; b++)
              if (ebuf[b] > ebuf[b+1]) begin
                etmp = ebuf[b]; ebuf[b] = ebuf[b+1]; ebuf[b+1] = etmp;
              end
          ocnt = 0;
          eout = 1'b1;
        end
      end
    end else if (bus.e_out_valid && bus.e_out_ready) begin
      ocnt++;
      if (ocnt == 10) begin
        eout = 1'b0;
        ecnt = 0;
      end
    end
    bus.e_in_ready  <= rst_n && !eout && (eng_stall ? ($urandom_range(0, 1) == 1) : 1'b1);
    bus.e_out_valid <= rst_n && eout;
    bus.e_out_data  <= (rst_n && eout) ? ebuf[ocnt] : 32'd0;
  end

  // Transfer monitor.
  always @(posedge axis_clk) begin
    if (rst_n) begin
      if (bus.ss_tvalid && bus.ss_tready) ss_fires++;
      if (bus.e_in_valid && bus.e_in_ready) begin
        ein_fires++;
        if (bus.e_in_data == 32'hFFFF_FFFF) pad_fires++;
      end
      if (bus.e_out_valid && bus.e_out_ready) eout_fires++;
      if (bus.sm_tvalid && bus.sm_tready) begin
        sm_fires++;
        rx_q.push_back({bus.sm_tlast, bus.sm_tdata});
        if (bus.sm_tlast) tl_cnt++;
      end
    end
  end

  // ---------------- scoreboard / driver tasks ----------------
  int n_cmp = 0, n_bad = 0;
  int b_ss, b_ein, b_pad, b_eout, b_sm;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge axis_clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge axis_clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge axis_clk);
    cfg_re = 1'b1; cfg_addr = a;
    @(negedge axis_clk);
    cfg_re = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic cfg_expect(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cfg_read(a, d);
    chk(tag, 33'(d), 33'(exp));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge axis_clk);
  endtask

  task automatic snap();
    b_ss = ss_fires; b_ein = ein_fires; b_pad = pad_fires; b_eout = eout_fires; b_sm = sm_fires;
  endtask

  task automatic wait_tlast(input string tag, input int target, input int budget);
    int c = 0;
    while (tl_cnt < target && c < budget) begin
      @(negedge axis_clk);
      c++;
    end
    chk({tag, "_tlast_seen"}, 33'(tl_cnt >= target), 33'd1);
  endtask

  task automatic check_rx(input string tag);
    logic [32:0] e, r;
    chk({tag, "_count"}, 33'(rx_q.size()), 33'(exp_q.size()));
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      chk({tag, "_word"}, r, e);
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ss_tready"},   33'(bus.ss_tready), 33'd0);
    chk({tag, "_e_in_valid"},  33'(bus.e_in_valid), 33'd0);
    chk({tag, "_e_out_ready"}, 33'(bus.e_out_ready), 33'd0);
    chk({tag, "_sm_tvalid"},   33'(bus.sm_tvalid), 33'd0);
    chk({tag, "_sm_tlast"},    33'(bus.sm_tlast), 33'd0);
    chk({tag, "_data"},        33'(bus.e_in_data | bus.sm_tdata), 33'd0);
    chk({tag, "_state"},       33'(dbg_state), 33'd0);
  endtask

  // ---------------- directed vectors (expected values by hand) ----------------
  int unsigned t2_in[13]  = '{50, 7, 33, 1000, 2, 19, 88, 5, 61, 12, 400, 3, 77};
  int unsigned t2_exp[13] = '{2, 5, 7, 12, 19, 33, 50, 61, 88, 1000, 3, 77, 400};
  int unsigned t3_in[5]   = '{40, 10, 30, 50, 20};
  int unsigned t5_in[20]  = '{15, 3, 9, 27, 1, 22, 8, 30, 11, 4, 6, 19, 2, 25, 14, 0, 17, 21, 5, 13};
  int unsigned t5_exp[20] = '{1, 3, 4, 8, 9, 11, 15, 22, 27, 30, 0, 2, 5, 6, 13, 14, 17, 19, 21, 25};
  int unsigned t6_in[10]  = '{5, 0, 8, 3, 9, 1, 7, 2, 6, 4};

  initial begin
    logic [31:0] d;
    int c;
    int target;

    // --- reset state ---
    rst_n = 1'b0;
    idle_cycles(3);
    check_outputs_zero("reset");
    chk("reset_cfg_rdata", 33'(cfg_rdata), 33'd0);
    rst_n = 1'b1;
    idle_cycles(1);
    cfg_expect("reset_ctrl", 8'h00, 32'h4);
    cfg_expect("unmapped_reads_0", 8'h08, 32'h0);
    cfg_expect("reset_len", 8'h10, 32'h0);
    cfg_expect("reset_perf", 8'h14, 32'h0);

    // --- LEN=10, words 9..0 ---
    cfg_write(8'h10, 32'd10);
    cfg_expect("t1_len", 8'h10, 32'd10);
    for (int i = 0; i < 10; i++) src_q.push_back({1'(i == 9), 32'(9 - i)});
    for (int i = 0; i < 10; i++) exp_q.push_back({1'(i == 9), 32'(i)});
    target = tl_cnt + 1;
    cfg_write(8'h00, 32'h1);
    chk("t1_ready_while_idle", 33'(bus.ss_tready), 33'd0);
    @(negedge axis_clk);
    chk("t1_feed_after_1cyc", 33'(dbg_state), 33'd1);
    chk("t1_ready_in_feed", 33'(bus.ss_tready), 33'd1);
    wait_tlast("t1", target, 200);
    idle_cycles(15);
    check_rx("t1");
    cfg_expect("t1_ctrl_done", 8'h00, 32'h6);
    cfg_expect("t1_ctrl_cleared", 8'h00, 32'h4);

    // --- LEN=13: two batches, 7 pads in the second ---
    cfg_write(8'h10, 32'd13);
    snap();
    for (int i = 0; i < 13; i++) src_q.push_back({1'(i == 12), 32'(t2_in[i])});
    for (int i = 0; i < 13; i++) exp_q.push_back({1'(i == 12), 32'(t2_exp[i])});
    target = tl_cnt + 1;
    cfg_write(8'h00, 32'h1);
    wait_tlast("t2", target, 300);
    idle_cycles(15);
    check_rx("t2");
    chk("t2_pads", 33'(pad_fires - b_pad), 33'd7);
    chk("t2_engine_pushes", 33'(ein_fires - b_ein), 33'd20);
    chk("t2_dropped", 33'((eout_fires - b_eout) - (sm_fires - b_sm)), 33'd7);
    cfg_expect("t2_ctrl_done", 8'h00, 32'h6);

    // --- LEN=12 with early tlast on word 5 ---
    cfg_write(8'h10, 32'd12);
    snap();
    for (int i = 0; i < 5; i++) src_q.push_back({1'(i == 4), 32'(t3_in[i])});
    for (int i = 0; i < 5; i++) exp_q.push_back({1'(i == 4), 32'((i + 1) * 10)});
    target = tl_cnt + 1;
    cfg_write(8'h00, 32'h1);
    wait_tlast("t3", target, 200);
    idle_cycles(15);
    check_rx("t3");
    chk("t3_pads", 33'(pad_fires - b_pad), 33'd5);
    chk("t3_accepted", 33'(ss_fires - b_ss), 33'd5);
    cfg_expect("t3_ctrl_err_done", 8'h00, 32'hE);
    cfg_expect("t3_ctrl_cleared", 8'h00, 32'h4);

    // --- LEN=0: straight to FIN; read lands on the done-set edge ---
    cfg_write(8'h10, 32'd0);
    snap();
    cfg_write(8'h00, 32'h1);
    cfg_expect("t4_read_on_set_edge", 8'h00, 32'h0);
    cfg_expect("t4_ctrl_done", 8'h00, 32'h6);
    cfg_expect("t4_ctrl_cleared", 8'h00, 32'h4);
    chk("t4_no_traffic", 33'((ss_fires - b_ss) + (ein_fires - b_ein) + (sm_fires - b_sm)), 33'd0);

    // --- LEN=20 with random engine/sink stalls; busy writes ignored ---
    eng_stall = 1'b1;
    sink_rand = 1'b1;
    cfg_write(8'h10, 32'd20);
    for (int i = 0; i < 20; i++) src_q.push_back({1'(i == 19), 32'(t5_in[i])});
    for (int i = 0; i < 20; i++) exp_q.push_back({1'(i == 19), 32'(t5_exp[i])});
    target = tl_cnt + 1;
    cfg_write(8'h00, 32'h1);
    cfg_write(8'h10, 32'd7);
    cfg_write(8'h00, 32'h1);
    wait_tlast("t5", target, 600);
    idle_cycles(20);
    check_rx("t5");
    cfg_expect("t5_ctrl_done", 8'h00, 32'h6);
    cfg_expect("t5_no_restart", 8'h00, 32'h4);
    cfg_expect("t5_len_kept", 8'h10, 32'd20);
    eng_stall = 1'b0;
    sink_rand = 1'b0;

    // --- reset during DRAIN of LEN=20, then a clean LEN=10 rerun ---
    for (int i = 0; i < 20; i++) src_q.push_back({1'(i == 19), 32'(t5_in[i])});
    snap();
    cfg_write(8'h00, 32'h1);
    c = 0;
    while ((sm_fires - b_sm) < 3 && c < 200) begin
      @(negedge axis_clk);
      c++;
    end
    chk("t6_reached_drain", 33'((sm_fires - b_sm) >= 3), 33'd1);
    rst_n = 1'b0;
    @(negedge axis_clk);
    check_outputs_zero("t6_reset");
    rst_n = 1'b1;
    idle_cycles(1);
    rx_q.delete();
    exp_q.delete();
    cfg_expect("t6_ctrl_after_reset", 8'h00, 32'h4);
    cfg_expect("t6_len_after_reset", 8'h10, 32'h0);
    cfg_write(8'h10, 32'd10);
    for (int i = 0; i < 10; i++) src_q.push_back({1'(i == 9), 32'(t6_in[i])});
    for (int i = 0; i < 10; i++) exp_q.push_back({1'(i == 9), 32'(i)});
    target = tl_cnt + 1;
    cfg_write(8'h00, 32'h1);
    wait_tlast("t6", target, 200);
    idle_cycles(15);
    check_rx("t6");
    cfg_expect("t6_ctrl_done", 8'h00, 32'h6);
    cfg_read(8'h14, d);
`ifdef QSORT_SCHED_PERF_EN
    chk("t6_perf_nonzero", 33'(d != 32'd0), 33'd1);
`else
    chk("t6_perf_absent", 33'(d), 33'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global bound in case a wait loop is never reached.
  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion expected finish before 500000");
    $fatal(1, "watchdog expired");
  end
endmodule
